// File: rtl/counter_defs.sv
// Shared encodings for the 4-bit mode counter family and its receive-side checker.
package counter_defs;

  localparam logic [1:0] MODE_UP  = 2'b00;
  localparam logic [1:0] MODE_DN  = 2'b01;
  localparam logic [1:0] MODE_DN3 = 2'b10;
  localparam logic [1:0] MODE_LD  = 2'b11;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    RUN    = 2'd1,
    HALT   = 2'd2
  } chk_state_e;

endpackage

// File: rtl/counter_model.sv
// Registered reference counter: reproduces exactly what a correct counterA/B/C
// should present on Q/rco/load after each rising edge.
module counter_model
  import counter_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dut_rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] exp_q,
  output logic             exp_rco,
  output logic             exp_load
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             load_q, load_d;

  always_comb begin
    q_d    = q_q;
    rco_d  = 1'b0;
    load_d = 1'b0;
    if (dut_rst) begin
      q_d = '0;
    end else if (enable) begin
      // rco flags the edge on which the arithmetic wraps modulo 2^WIDTH
      case (mode)
        MODE_UP: begin
          q_d   = q_q + WIDTH'(1);
          rco_d = &q_q;
        end
        MODE_DN: begin
          q_d   = q_q - WIDTH'(1);
          rco_d = ~|q_q;
        end
        MODE_DN3: begin
          q_d   = q_q - WIDTH'(3);
          rco_d = (q_q < WIDTH'(3));
        end
        default: begin
          q_d    = D;
          load_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
    end
  end

  assign exp_q    = q_q;
  assign exp_rco  = rco_q;
  assign exp_load = load_q;

endmodule

// File: rtl/counter_checker.sv
// Receive-side checker: runs the reference counter beside the DUT and tallies
// per-cycle compares, mismatches and the first mismatching sample.
module counter_checker
  import counter_defs::*;
#(
  parameter int WIDTH   = 4,
  parameter int ERR_W   = 8,
  parameter int CHK_W   = 16,
  parameter int MAX_ERR = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dut_rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   D,
  input  logic [WIDTH-1:0]   dut_q,
  input  logic               dut_rco,
  input  logic               dut_load,
  output logic [WIDTH-1:0]   exp_q,
  output logic               exp_rco,
  output logic               exp_load,
  output logic               synced,
  output logic               error,
  output logic               halted,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [CHK_W-1:0]   chk_cnt,
  output logic               first_valid,
  output logic [WIDTH+1:0]   first_exp,
  output logic [WIDTH+1:0]   first_got
);

  chk_state_e       state_q, state_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [CHK_W-1:0] chk_cnt_q, chk_cnt_d;
  logic             error_q, error_d;
  logic             first_valid_q, first_valid_d;
  logic [WIDTH+1:0] first_exp_q, first_exp_d;
  logic [WIDTH+1:0] first_got_q, first_got_d;
  logic [WIDTH+1:0] exp_vec, got_vec;

  counter_model #(.WIDTH(WIDTH)) u_model (
    .clk      (clk),
    .reset    (reset),
    .dut_rst  (dut_rst),
    .enable   (enable),
    .mode     (mode),
    .D        (D),
    .exp_q    (exp_q),
    .exp_rco  (exp_rco),
    .exp_load (exp_load)
  );

  // Both vectors reflect the previous edge, so they are directly comparable.
  assign exp_vec = {exp_q, exp_rco, exp_load};
  assign got_vec = {dut_q, dut_rco, dut_load};

  always_comb begin
    state_d       = state_q;
    err_cnt_d     = err_cnt_q;
    chk_cnt_d     = chk_cnt_q;
    error_d       = error_q;
    first_valid_d = first_valid_q;
    first_exp_d   = first_exp_q;
    first_got_d   = first_got_q;
    case (state_q)
      UNSYNC: begin
        if (dut_rst) state_d = RUN;
      end
      RUN: begin
        if (chk_cnt_q != '1) chk_cnt_d = chk_cnt_q + CHK_W'(1);
        if (exp_vec != got_vec) begin
          error_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          if (!first_valid_q) begin
            first_valid_d = 1'b1;
            first_exp_d   = exp_vec;
            first_got_d   = got_vec;
          end
        end
        if (err_cnt_d == ERR_W'(MAX_ERR)) state_d = HALT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= UNSYNC;
      err_cnt_q     <= '0;
      chk_cnt_q     <= '0;
      error_q       <= 1'b0;
      first_valid_q <= 1'b0;
      first_exp_q   <= '0;
      first_got_q   <= '0;
    end else begin
      state_q       <= state_d;
      err_cnt_q     <= err_cnt_d;
      chk_cnt_q     <= chk_cnt_d;
      error_q       <= error_d;
      first_valid_q <= first_valid_d;
      first_exp_q   <= first_exp_d;
      first_got_q   <= first_got_d;
    end
  end

  assign synced      = (state_q != UNSYNC);
  assign halted      = (state_q == HALT);
  assign error       = error_q;
  assign err_cnt     = err_cnt_q;
  assign chk_cnt     = chk_cnt_q;
  assign first_valid = first_valid_q;
  assign first_exp   = first_exp_q;
  assign first_got   = first_got_q;

endmodule
